// File: rtl/uart_arb_pkg.sv
// Shared types and helpers for the round-robin UART TX arbiter.
// State encodings, byte width and index-width function.
package uart_arb_pkg;

    localparam int BYTE_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_GAP  = 2'd2
    } state_e;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 32; i++) begin
            if ((1 << r) < n) r++;
        end
        return r;
    endfunction

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// Requester-side and transmitter-side handshake bundle of the arbiter.
// master = arbiter view, slave = environment view.
interface uart_tx_arbiter_if
    import uart_arb_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int CNT_W = 16
);
    localparam int IDX_W = clog2(N_REQ);

    logic [N_REQ-1:0]        req_valid;
    logic [BYTE_W*N_REQ-1:0] req_data;
    logic [N_REQ-1:0]        req_last;
    logic [N_REQ-1:0]        req_ready;
    logic                    tx_valid;
    logic [BYTE_W-1:0]       tx_data;
    logic                    tx_ready;
    logic [IDX_W-1:0]        grant_id;
    logic                    busy;
    logic [CNT_W-1:0]        byte_count;

    modport master (
        input  req_valid, req_data, req_last, tx_ready,
        output req_ready, tx_valid, tx_data, grant_id, busy, byte_count
    );

    modport slave (
        output req_valid, req_data, req_last, tx_ready,
        input  req_ready, tx_valid, tx_data, grant_id, busy, byte_count
    );

endinterface

// File: rtl/uart_rr_picker.sv
// Combinational round-robin picker: first set bit of req after ptr,
// wrapping modulo N.
module uart_rr_picker
    import uart_arb_pkg::*;
#(
    parameter int N  = 4,
    parameter int IW = clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] idx,
    output logic          any
);

    always_comb begin
        idx = '0;
        any = 1'b0;
        for (int i = 1; i <= N; i++) begin
            if (!any && req[IW'((int'(ptr) + i) % N)]) begin
                any = 1'b1;
                idx = IW'((int'(ptr) + i) % N);
            end
        end
        gnt = any ? (N'(1) << idx) : '0;
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART byte transmitter among N_REQ sources.
// Define UART_ARB_PKT_LOCK_EN to hold the grant until a req_last byte.
module uart_tx_arbiter
    import uart_arb_pkg::*;
#(
    parameter int N_REQ      = 4,
    parameter int GAP_CYCLES = 0,
    parameter int CNT_W      = 16
) (
    input logic              clk,
    input logic              rst,
    uart_tx_arbiter_if.master bus
);

    localparam int IDX_W = clog2(N_REQ);

    state_e             state_q, state_d;
    logic               tx_valid_q, tx_valid_d;
    logic [BYTE_W-1:0]  tx_data_q, tx_data_d;
    logic [IDX_W-1:0]   grant_q, grant_d;
    logic [IDX_W-1:0]   ptr_q, ptr_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [15:0]        gap_q, gap_d;

    logic [N_REQ-1:0]   mask;
    logic [N_REQ-1:0]   pick_gnt;
    logic [IDX_W-1:0]   pick_idx;
    logic               pick_any;
    logic [BYTE_W-1:0]  req_byte [N_REQ];

`ifdef UART_ARB_PKT_LOCK_EN
    logic               lock_q, lock_d;

    // A locked packet narrows arbitration to its owner only.
    assign mask = lock_q ? (bus.req_valid & (N_REQ'(1) << grant_q))
                         : bus.req_valid;
`else
    assign mask = bus.req_valid;
`endif

    uart_rr_picker #(
        .N  (N_REQ),
        .IW (IDX_W)
    ) u_picker (
        .req (mask),
        .ptr (ptr_q),
        .gnt (pick_gnt),
        .idx (pick_idx),
        .any (pick_any)
    );

    always_comb begin
        for (int i = 0; i < N_REQ; i++) begin
            req_byte[i] = bus.req_data[i*BYTE_W +: BYTE_W];
        end
    end

    assign bus.req_ready  = (state_q == ST_IDLE && !rst) ? pick_gnt : '0;
    assign bus.tx_valid   = tx_valid_q;
    assign bus.tx_data    = tx_data_q;
    assign bus.grant_id   = grant_q;
    assign bus.busy       = (state_q != ST_IDLE);
    assign bus.byte_count = cnt_q;

    always_comb begin
        state_d    = state_q;
        tx_valid_d = tx_valid_q;
        tx_data_d  = tx_data_q;
        grant_d    = grant_q;
        ptr_d      = ptr_q;
        cnt_d      = cnt_q;
        gap_d      = gap_q;
`ifdef UART_ARB_PKT_LOCK_EN
        lock_d     = lock_q;
`endif
        unique case (state_q)
            ST_IDLE: begin
                if (pick_any) begin
                    state_d    = ST_SEND;
                    tx_valid_d = 1'b1;
                    tx_data_d  = req_byte[pick_idx];
                    grant_d    = pick_idx;
                    ptr_d      = pick_idx;
`ifdef UART_ARB_PKT_LOCK_EN
                    lock_d     = ~bus.req_last[pick_idx];
`endif
                end
            end
            ST_SEND: begin
                if (bus.tx_ready) begin
                    cnt_d      = cnt_q + 1'b1;
                    tx_valid_d = 1'b0;
                    if (GAP_CYCLES > 0) begin
                        state_d = ST_GAP;
                        gap_d   = 16'(GAP_CYCLES - 1);
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            ST_GAP: begin
                if (gap_q == 16'd0) state_d = ST_IDLE;
                else                gap_d   = gap_q - 16'd1;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            tx_valid_q <= 1'b0;
            tx_data_q  <= '0;
            grant_q    <= '0;
            ptr_q      <= IDX_W'(N_REQ - 1);
            cnt_q      <= '0;
            gap_q      <= '0;
`ifdef UART_ARB_PKT_LOCK_EN
            lock_q     <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            tx_valid_q <= tx_valid_d;
            tx_data_q  <= tx_data_d;
            grant_q    <= grant_d;
            ptr_q      <= ptr_d;
            cnt_q      <= cnt_d;
            gap_q      <= gap_d;
`ifdef UART_ARB_PKT_LOCK_EN
            lock_q     <= lock_d;
`endif
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: two instances (no gap / 3-cycle gap, 4-bit
// counter) driven in parallel and checked against a behavioural model.
module tb_uart_tx_arbiter;
    import uart_arb_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  r_valid = 4'h0;
    logic [3:0]  r_last = 4'hF;
    logic [31:0] r_data = 32'h0;
    logic        r_ready = 1'b0;

    always #5 clk = ~clk;

    uart_tx_arbiter_if #(.N_REQ(4), .CNT_W(16)) if0 ();
    uart_tx_arbiter_if #(.N_REQ(4), .CNT_W(4))  if3 ();

    assign if0.req_valid = r_valid;
    assign if0.req_data  = r_data;
    assign if0.req_last  = r_last;
    assign if0.tx_ready  = r_ready;
    assign if3.req_valid = r_valid;
    assign if3.req_data  = r_data;
    assign if3.req_last  = r_last;
    assign if3.tx_ready  = r_ready;

    uart_tx_arbiter #(.N_REQ(4), .GAP_CYCLES(0), .CNT_W(16)) dut0 (
        .clk (clk),
        .rst (rst),
        .bus (if0)
    );

    uart_tx_arbiter #(.N_REQ(4), .GAP_CYCLES(3), .CNT_W(4)) dut3 (
        .clk (clk),
        .rst (rst),
        .bus (if3)
    );

    logic [3:0]  o_ready [2];
    logic        o_valid [2];
    logic [7:0]  o_data  [2];
    logic [1:0]  o_gid   [2];
    logic        o_busy  [2];
    logic [15:0] o_cnt   [2];

    assign o_ready[0] = if0.req_ready;
    assign o_valid[0] = if0.tx_valid;
    assign o_data[0]  = if0.tx_data;
    assign o_gid[0]   = if0.grant_id;
    assign o_busy[0]  = if0.busy;
    assign o_cnt[0]   = if0.byte_count;
    assign o_ready[1] = if3.req_ready;
    assign o_valid[1] = if3.tx_valid;
    assign o_data[1]  = if3.tx_data;
    assign o_gid[1]   = if3.grant_id;
    assign o_busy[1]  = if3.busy;
    assign o_cnt[1]   = {12'h0, if3.byte_count};

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference model: one transmitter slot, a gap timer, a rr pointer.
    int        GAPV [2] = '{0, 3};
    int        MODV [2] = '{65536, 16};
    bit        m_hold [2];
    logic [7:0] m_data [2];
    int        m_id   [2];
    int        m_ptr  [2];
    int        m_wait [2];
    int        m_cnt  [2];
    bit        m_lock [2];
    bit        started = 1'b0;

    function automatic logic [7:0] byte_of(input logic [31:0] d, input int i);
        return 8'(d >> (8 * i));
    endfunction

    function automatic int pick(input int k, input logic [3:0] v);
        int j;
`ifdef UART_ARB_PKT_LOCK_EN
        if (m_lock[k]) return v[2'(m_id[k])] ? m_id[k] : -1;
`endif
        for (int i = 1; i <= 4; i++) begin
            j = (m_ptr[k] + i) % 4;
            if (v[2'(j)]) return j;
        end
        return -1;
    endfunction

    initial begin
        for (int k = 0; k < 2; k++) begin
            m_hold[k] = 0; m_data[k] = 8'h0; m_id[k] = 0;
            m_ptr[k] = 3; m_wait[k] = 0; m_cnt[k] = 0; m_lock[k] = 0;
        end
        forever begin
            int w;
            @(posedge clk);
            started = 1'b1;
            for (int k = 0; k < 2; k++) begin
                if (rst) begin
                    m_hold[k] = 0; m_data[k] = 8'h0; m_id[k] = 0;
                    m_ptr[k] = 3; m_wait[k] = 0; m_cnt[k] = 0; m_lock[k] = 0;
                end else if (m_hold[k]) begin
                    if (r_ready) begin
                        m_cnt[k]  = (m_cnt[k] + 1) % MODV[k];
                        m_hold[k] = 0;
                        m_wait[k] = GAPV[k];
                    end
                end else if (m_wait[k] > 0) begin
                    m_wait[k]--;
                end else begin
                    w = pick(k, r_valid);
                    if (w >= 0) begin
                        m_hold[k] = 1;
                        m_data[k] = byte_of(r_data, w);
                        m_id[k]   = w;
                        m_ptr[k]  = w;
                        m_lock[k] = !r_last[2'(w)];
                    end
                end
            end
        end
    end

    initial begin
        forever begin
            int w;
            bit eb;
            @(negedge clk);
            if (started) begin
                for (int k = 0; k < 2; k++) begin
                    eb = m_hold[k] || (m_wait[k] > 0);
                    w  = (rst || eb) ? -1 : pick(k, r_valid);
                    chk($sformatf("m%0d_ready", k), 32'(o_ready[k]),
                        (w < 0) ? 32'h0 : 32'(1 << w));
                    chk($sformatf("m%0d_valid", k), 32'(o_valid[k]), 32'(m_hold[k]));
                    chk($sformatf("m%0d_data", k), 32'(o_data[k]), 32'(m_data[k]));
                    chk($sformatf("m%0d_gid", k), 32'(o_gid[k]), 32'(m_id[k]));
                    chk($sformatf("m%0d_busy", k), 32'(o_busy[k]), 32'(eb));
                    chk($sformatf("m%0d_cnt", k), 32'(o_cnt[k]), 32'(m_cnt[k]));
                end
            end
        end
    end

    // Handshake monitor
    int          cyc = 0;
    int          qg[$];
    logic [7:0]  qd[$];
    int          t3[$];

    initial begin
        forever begin
            @(posedge clk);
            cyc++;
            if (!rst && if0.tx_valid && if0.tx_ready) begin
                qg.push_back(int'(if0.grant_id));
                qd.push_back(if0.tx_data);
            end
            if (!rst && if3.tx_valid && if3.tx_ready) t3.push_back(cyc);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int rr_exp [6] = '{0, 1, 2, 3, 0, 1};
        logic [7:0] lk_exp [5];
        logic [7:0] d0;
        logic [1:0] g0;
        int c0, n, i0, i2;
        bit stable, a0, a2;

        // Reset with every requester asking
        r_valid = 4'hF;
        r_data  = $urandom;
        tick(); tick();
        @(negedge clk);
        chk("rst_ready", 32'(if0.req_ready), 32'h0);
        tick();
        rst = 1'b0; r_valid = 4'h0;
        @(negedge clk);
        chk("rst_valid", 32'(if0.tx_valid), 32'h0);
        chk("rst_busy", 32'(if0.busy), 32'h0);
        chk("rst_cnt", 32'(if0.byte_count), 32'h0);
        chk("rst_gid", 32'(if0.grant_id), 32'h0);

        // Single request
        tick();
        r_valid = 4'b0010; r_data = 32'h0000A500;
        @(negedge clk);
        chk("t1_ready", 32'(if0.req_ready), 32'h2);
        tick();
        r_valid = 4'h0;
        @(negedge clk);
        chk("t1_valid", 32'(if0.tx_valid), 32'h1);
        chk("t1_data", 32'(if0.tx_data), 32'hA5);
        chk("t1_gid", 32'(if0.grant_id), 32'h1);
        tick(); tick();
        r_ready = 1'b1;
        tick();
        r_ready = 1'b0;
        @(negedge clk);
        chk("t1_cnt", 32'(if0.byte_count), 32'h1);
        chk("t1_busy", 32'(if0.busy), 32'h0);

        // Round robin, all valid
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0; r_valid = 4'hF; r_ready = 1'b1; r_data = $urandom;
        qg.delete(); qd.delete();
        repeat (12) tick();
        r_valid = 4'h0; r_ready = 1'b0;
        @(negedge clk);
        chk("t2_cnt", 32'(if0.byte_count), 32'h6);
        chk("t2_n", 32'(qg.size()), 32'h6);
        for (int i = 0; i < 6 && i < qg.size(); i++)
            chk($sformatf("t2_order%0d", i), 32'(qg[i]), 32'(rr_exp[i]));

        // Backpressure
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0; r_valid = 4'hF; r_data = $urandom;
        tick();
        @(negedge clk);
        d0 = if0.tx_data; g0 = if0.grant_id; c0 = int'(if0.byte_count);
        chk("t3_gid0", 32'(g0), 32'h0);
        stable = 1'b1;
        repeat (100) begin
            tick();
            r_valid = 4'($urandom); r_data = $urandom;
            @(negedge clk);
            if (if0.tx_valid !== 1'b1 || if0.tx_data !== d0 ||
                if0.grant_id !== g0 || if0.req_ready !== 4'h0) stable = 1'b0;
        end
        chk("t3_stable", 32'(stable), 32'h1);
        tick();
        r_valid = 4'h0; r_ready = 1'b1;
        tick();
        r_ready = 1'b0;
        repeat (3) tick();
        @(negedge clk);
        chk("t3_cnt", 32'(if0.byte_count), 32'(c0 + 1));

        // Gap spacing on the GAP_CYCLES=3 instance
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0; r_valid = 4'b0001; r_ready = 1'b1;
        t3.delete();
        repeat (30) tick();
        r_valid = 4'h0;
        @(negedge clk);
        chk("t4_n", 32'(t3.size() >= 5), 32'h1);
        for (int i = 1; i < 5 && i < t3.size(); i++)
            chk($sformatf("t4_period%0d", i), 32'(t3[i] - t3[i-1]), 32'h5);

        // Counter wrap on the 4-bit instance
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0; r_valid = 4'b0001; r_ready = 1'b1;
        n = 0;
        while (if3.byte_count != 4'hF && n < 200) begin
            tick();
            n++;
        end
        chk("wrap_reach", 32'(n < 200), 32'h1);
        n = 0;
        while (if3.byte_count == 4'hF && n < 20) begin
            tick();
            n++;
        end
        chk("wrap_zero", 32'(if3.byte_count), 32'h0);
        r_valid = 4'h0; r_ready = 1'b0;

        // Reset during SEND
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0; r_valid = 4'b0001; r_data = 32'h0000003C;
        tick();
        r_valid = 4'h0;
        @(negedge clk);
        chk("t5_data", 32'(if0.tx_data), 32'h3C);
        tick();
        rst = 1'b1; r_valid = 4'b1001;
        @(negedge clk);
        chk("t5_rst_ready", 32'(if0.req_ready), 32'h0);
        tick();
        rst = 1'b0;
        @(negedge clk);
        chk("t5_valid", 32'(if0.tx_valid), 32'h0);
        chk("t5_cnt", 32'(if0.byte_count), 32'h0);
        chk("t5_busy", 32'(if0.busy), 32'h0);
        chk("t5_ready", 32'(if0.req_ready), 32'h1);
        tick();
        r_valid = 4'h0;
        @(negedge clk);
        chk("t5_gid", 32'(if0.grant_id), 32'h0);

        // Packet lock: move pointer to 1, then req2 packet vs req0
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0; r_valid = 4'b0010; r_last = 4'hF; r_ready = 1'b1;
        tick();
        r_valid = 4'h0;
        tick();
        qg.delete(); qd.delete();
        i0 = 0; i2 = 0;
        r_valid = 4'b0101;
        r_data  = 32'h00100050;
        r_last  = 4'b1011;
        repeat (20) begin
            @(negedge clk);
            a0 = if0.req_ready[0];
            a2 = if0.req_ready[2];
            tick();
            if (a2) begin
                i2++;
                if (i2 == 3) r_valid[2] = 1'b0;
                r_data[23:16] = 8'(8'h10 + i2);
                r_last[2] = (i2 == 2);
            end
            if (a0) begin
                i0++;
                r_data[7:0] = 8'(8'h50 + i0);
            end
        end
        r_valid = 4'h0; r_last = 4'hF;
`ifdef UART_ARB_PKT_LOCK_EN
        lk_exp = '{8'h10, 8'h11, 8'h12, 8'h50, 8'h51};
`else
        lk_exp = '{8'h10, 8'h50, 8'h11, 8'h51, 8'h12};
`endif
        @(negedge clk);
        chk("t6_n", 32'(qd.size() >= 5), 32'h1);
        for (int i = 0; i < 5 && i < qd.size(); i++)
            chk($sformatf("t6_byte%0d", i), 32'(qd[i]), 32'(lk_exp[i]));

        // Randomized traffic, checked by the model every cycle
        repeat (3000) begin
            tick();
            rst     = ($urandom_range(0, 99) == 0);
            r_valid = 4'($urandom);
            r_data  = $urandom;
            r_last  = 4'($urandom);
            r_ready = ($urandom_range(0, 2) != 0);
        end
        tick();
        rst = 1'b0; r_valid = 4'h0; r_ready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
